// File: rtl/byte_rot_pkg.sv
// rtl/byte_rot_pkg.sv - shared types, sizes and helpers for the byte rotation sequencer
//
// Contents:
//   BYTES / BYTE_W / WORD_W   datapath geometry (8 bytes of 8 bits, 32-bit words)
//   state_e                   sequencer FSM state encoding
//   next_sel()                rotation amount advance with wrap 7 -> 0
//   byte_parity()             per-byte XOR of a 64-bit word (BYTE_ROT_PARITY_EN only)

package byte_rot_pkg;

  localparam int BYTES  = 8;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

  // Rotation amount is 3 bits wide, so natural overflow gives the modulo-8 wrap.
  function automatic logic [2:0] next_sel(input logic [2:0] sel);
    return sel + 3'd1;
  endfunction

`ifdef BYTE_ROT_PARITY_EN
  // Bit i is the XOR of byte i, byte 0 being the least significant byte.
  function automatic logic [BYTES-1:0] byte_parity(input logic [BYTES*BYTE_W-1:0] data);
    logic [BYTES-1:0] p;
    for (int i = 0; i < BYTES; i++) begin
      p[i] = ^data[i*BYTE_W +: BYTE_W];
    end
    return p;
  endfunction
`endif

endpackage

// File: rtl/rot_lat_counter.sv
// rtl/rot_lat_counter.sv - wait-cycle down-counter covering the rotation matrix latency
//
// Loaded with ROT_LAT-1 while the sequencer issues a rotation, decremented
// once per wait cycle; done flags the last wait cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         reload with ROT_LAT-1
//   dec          count down one wait cycle
//   done         current cycle is the last wait cycle

module rot_lat_counter #(
  parameter int ROT_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  // ROT_LAT is at most 4, so ROT_LAT-1 fits in two bits.
  localparam logic [1:0] LOAD_VAL = 2'(ROT_LAT - 1);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q <= 2'd1);

endmodule

// File: rtl/byte_rot_sequencer.sv
// rtl/byte_rot_sequencer.sv - job sequencer driving the 64-bit byte-rotation matrix
//
// Accepts a job {R1, R2, start rotation, step count}, issues one rotation per
// step to the matrix, captures the returned bytes and presents one 64-bit
// result per step on a valid/ready output stream.
//
// Ports:
//   clk1, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready               job handshake; in_ready is high only in IDLE
//   in_r1, in_r2                    source words
//   in_sel_start, in_count          first rotation amount, steps (0 means 8)
//   rot_r1/rot_r2/rot_select/rot_enable   matrix drive
//   rot_bytes                       matrix result {Out1..Out8}, Out1 at [63:56]
//   out_valid/out_ready             result handshake
//   out_data, out_sel, out_last     captured result, its rotation amount, final flag
//   out_parity                      per-byte parity of out_data (BYTE_ROT_PARITY_EN)
//
// Build option: define BYTE_ROT_PARITY_EN to add the out_parity port.

module byte_rot_sequencer
  import byte_rot_pkg::*;
#(
  parameter int ROT_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       in_r1,
  input  logic [WORD_W-1:0]       in_r2,
  input  logic [2:0]              in_sel_start,
  input  logic [CNT_W-1:0]        in_count,
  output logic [WORD_W-1:0]       rot_r1,
  output logic [WORD_W-1:0]       rot_r2,
  output logic [2:0]              rot_select,
  output logic                    rot_enable,
  input  logic [BYTES*BYTE_W-1:0] rot_bytes,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BYTES*BYTE_W-1:0] out_data,
  output logic [2:0]              out_sel,
`ifdef BYTE_ROT_PARITY_EN
  output logic [BYTES-1:0]        out_parity,
`endif
  output logic                    out_last
);

  // Remaining-steps counter must be able to hold 8 even for narrow in_count.
  localparam int REM_W = (CNT_W > 4) ? CNT_W : 4;

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       rot_r1_q, rot_r1_d;
  logic [WORD_W-1:0]       rot_r2_q, rot_r2_d;
  logic [2:0]              rot_select_q, rot_select_d;
  logic                    rot_enable_q, rot_enable_d;
  logic                    out_valid_q, out_valid_d;
  logic [BYTES*BYTE_W-1:0] out_data_q, out_data_d;
  logic [2:0]              out_sel_q, out_sel_d;
  logic                    out_last_q, out_last_d;
  logic [REM_W-1:0]        rem_q, rem_d;
`ifdef BYTE_ROT_PARITY_EN
  logic [BYTES-1:0]        out_parity_q, out_parity_d;
`endif

  logic lat_load;
  logic lat_dec;
  logic lat_done;

  rot_lat_counter #(
    .ROT_LAT (ROT_LAT)
  ) u_lat (
    .clk   (clk1),
    .rst_n (rst_n),
    .load  (lat_load),
    .dec   (lat_dec),
    .done  (lat_done)
  );

  always_comb begin
    state_d      = state_q;
    rot_r1_d     = rot_r1_q;
    rot_r2_d     = rot_r2_q;
    rot_select_d = rot_select_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_last_d   = out_last_q;
    rem_d        = rem_q;
`ifdef BYTE_ROT_PARITY_EN
    out_parity_d = out_parity_q;
`endif
    lat_load     = 1'b0;
    lat_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rot_r1_d     = in_r1;
          rot_r2_d     = in_r2;
          rot_select_d = in_sel_start;
          rem_d        = (in_count == '0) ? REM_W'(8) : REM_W'(in_count);
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_load = 1'b1;
        state_d  = (ROT_LAT > 1) ? ST_WAIT : ST_CAPTURE;
      end
      ST_WAIT: begin
        lat_dec = 1'b1;
        if (lat_done) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        out_data_d   = rot_bytes;
        out_sel_d    = rot_select_q;
        out_last_d   = (rem_q == REM_W'(1));
`ifdef BYTE_ROT_PARITY_EN
        out_parity_d = byte_parity(rot_bytes);
`endif
        state_d      = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (rem_q == REM_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            rot_select_d = next_sel(rot_select_q);
            rem_d        = rem_q - REM_W'(1);
            state_d      = ST_ISSUE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs tied to the state being entered so they change with it, glitch-free.
    rot_enable_d = (state_d == ST_ISSUE);
    out_valid_d  = (state_d == ST_OUT);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rot_r1_q     <= '0;
      rot_r2_q     <= '0;
      rot_select_q <= '0;
      rot_enable_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_last_q   <= 1'b0;
      rem_q        <= '0;
`ifdef BYTE_ROT_PARITY_EN
      out_parity_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rot_r1_q     <= rot_r1_d;
      rot_r2_q     <= rot_r2_d;
      rot_select_q <= rot_select_d;
      rot_enable_q <= rot_enable_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_last_q   <= out_last_d;
      rem_q        <= rem_d;
`ifdef BYTE_ROT_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign rot_r1     = rot_r1_q;
  assign rot_r2     = rot_r2_q;
  assign rot_select = rot_select_q;
  assign rot_enable = rot_enable_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sel    = out_sel_q;
  assign out_last   = out_last_q;
`ifdef BYTE_ROT_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule
